// File: rtl/rc4_pkg.sv
// rc4_pkg: shared FSM state encoding and default sizes for the RC4 keystream core
package rc4_pkg;
    typedef enum logic [2:0] {S_LOAD, S_INIT, S_KSA, S_DROP, S_PRGA} state_t;
    localparam int DEF_W = 8;
    localparam int DEF_MAX_KEY_LEN = 32;
endpackage

// File: rtl/rc4_sbox.sv
// rc4_sbox: 2**W x W permutation store with swap, identity-init and forwarded t read
// Ports:
//   clk          clock
//   i_init_we    write S[i_init_addr] = i_init_addr (identity fill)
//   i_init_addr  identity fill address
//   i_swap       swap S[i_addr_i] and S[i_addr_j] at the clock edge
//   i_addr_i/j   async read addresses, data on o_s_i/o_s_j (pre-swap values)
//   i_addr_t     async read address, o_s_t returns the value as it will be after the swap
module rc4_sbox #(
    parameter int W = 8
)(
    input  logic         clk,
    input  logic         i_init_we,
    input  logic [W-1:0] i_init_addr,
    input  logic         i_swap,
    input  logic [W-1:0] i_addr_i,
    input  logic [W-1:0] i_addr_j,
    input  logic [W-1:0] i_addr_t,
    output logic [W-1:0] o_s_i,
    output logic [W-1:0] o_s_j,
    output logic [W-1:0] o_s_t
);
    logic [W-1:0] r_s [2**W];
    assign o_s_i = r_s[i_addr_i];
    assign o_s_j = r_s[i_addr_j];
    // Post-swap view; when i==j both branches yield the same unchanged entry
    assign o_s_t = (i_addr_t == i_addr_i) ? o_s_j :
                   (i_addr_t == i_addr_j) ? o_s_i : r_s[i_addr_t];
    always_ff @(posedge clk) begin
        if (i_init_we) begin
            r_s[i_init_addr] <= i_init_addr;
        end else if (i_swap) begin
            r_s[i_addr_i] <= o_s_j;
            r_s[i_addr_j] <= o_s_i;
        end
    end
endmodule

// File: rtl/rc4_stream.sv
// rc4_stream: RC4 keystream generator with key handshake, optional drop[N] and backpressured output
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   i_restart     1-cycle pulse: drop the stream and return to key loading
//   i_key_valid   key word valid; o_key_ready high only while loading
//   i_key_data    key word, first word first
//   i_key_last    final key word marker
//   o_ks_valid    keystream word valid; i_ks_ready consumer accept
//   o_ks_data     keystream word
//   o_busy        high while initialising, scheduling or dropping
module rc4_stream
    import rc4_pkg::*;
#(
    parameter int W           = DEF_W,
    parameter int MAX_KEY_LEN = DEF_MAX_KEY_LEN,
    parameter int DROP_N      = 0
)(
    input  logic         clk,
    input  logic         rst,
    input  logic         i_restart,
    input  logic         i_key_valid,
    output logic         o_key_ready,
    input  logic [W-1:0] i_key_data,
    input  logic         i_key_last,
    output logic         o_ks_valid,
    input  logic         i_ks_ready,
    output logic [W-1:0] o_ks_data,
    output logic         o_busy
);
    localparam int KW = $clog2(MAX_KEY_LEN + 1);
    localparam int KI = $clog2(MAX_KEY_LEN);
    localparam int DW = $clog2(DROP_N + 2);
    localparam logic [W-1:0]  W_MAX     = {W{1'b1}};
    localparam logic [DW-1:0] DROP_LAST = DW'(DROP_N == 0 ? 0 : DROP_N - 1);

    state_t        r_state;
    logic          r_key_ready;
    logic          r_busy;
    logic          r_ks_valid;
    logic [W-1:0]  r_ks_data;
    logic [W-1:0]  r_i;
    logic [W-1:0]  r_j;
    logic [KI-1:0] r_kidx;
    logic [KW-1:0] r_key_len;
    logic [DW-1:0] r_drop;
    logic [W-1:0]  r_key [MAX_KEY_LEN];

    logic          w_ksa;
    logic          w_step;
    logic          w_swap;
    logic [W-1:0]  w_ip;
    logic [W-1:0]  w_jp;
    logic [W-1:0]  w_j_ksa;
    logic [W-1:0]  w_addr_i;
    logic [W-1:0]  w_addr_j;
    logic [W-1:0]  w_t;
    logic [W-1:0]  w_s_i;
    logic [W-1:0]  w_s_j;
    logic [W-1:0]  w_s_t;
    logic [KI-1:0] w_klast;

    assign w_ksa    = r_state == S_KSA;
    // A PRGA step only happens when the output register is free or being drained
    assign w_step   = r_state == S_PRGA && (!r_ks_valid || i_ks_ready);
    assign w_swap   = w_ksa || r_state == S_DROP || w_step;
    assign w_ip     = r_i + 1'b1;
    assign w_jp     = r_j + w_s_i;
    assign w_j_ksa  = r_j + w_s_i + r_key[r_kidx];
    assign w_addr_i = w_ksa ? r_i : w_ip;
    assign w_addr_j = w_ksa ? w_j_ksa : w_jp;
    assign w_t      = w_s_i + w_s_j;
    assign w_klast  = KI'(r_key_len - 1'b1);

    rc4_sbox #(.W(W)) u_sbox (
        .clk        (clk),
        .i_init_we  (r_state == S_INIT),
        .i_init_addr(r_i),
        .i_swap     (w_swap),
        .i_addr_i   (w_addr_i),
        .i_addr_j   (w_addr_j),
        .i_addr_t   (w_t),
        .o_s_i      (w_s_i),
        .o_s_j      (w_s_j),
        .o_s_t      (w_s_t)
    );

    always_ff @(posedge clk) begin
        if (!rst && !i_restart && r_state == S_LOAD && i_key_valid)
            r_key[r_key_len[KI-1:0]] <= i_key_data;
    end

    always_ff @(posedge clk) begin
        if (rst || i_restart) begin
            r_state     <= S_LOAD;
            r_key_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_ks_valid  <= 1'b0;
            r_ks_data   <= '0;
            r_i         <= '0;
            r_j         <= '0;
            r_kidx      <= '0;
            r_key_len   <= '0;
            r_drop      <= '0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (i_key_valid) begin
                        r_key_len <= r_key_len + 1'b1;
                        if (i_key_last || r_key_len == KW'(MAX_KEY_LEN - 1)) begin
                            r_state     <= S_INIT;
                            r_key_ready <= 1'b0;
                            r_busy      <= 1'b1;
                        end
                    end
                end
                S_INIT: begin
                    r_i <= r_i + 1'b1;
                    if (r_i == W_MAX) begin
                        r_state <= S_KSA;
                        r_j     <= '0;
                        r_kidx  <= '0;
                    end
                end
                S_KSA: begin
                    r_i    <= r_i + 1'b1;
                    r_j    <= w_j_ksa;
                    r_kidx <= (r_kidx == w_klast) ? '0 : r_kidx + 1'b1;
                    if (r_i == W_MAX) begin
                        r_j     <= '0;
                        r_drop  <= '0;
                        r_state <= DROP_N == 0 ? S_PRGA : S_DROP;
                        r_busy  <= DROP_N != 0;
                    end
                end
                S_DROP: begin
                    r_i    <= w_ip;
                    r_j    <= w_jp;
                    r_drop <= r_drop + 1'b1;
                    if (r_drop == DROP_LAST) begin
                        r_state <= S_PRGA;
                        r_busy  <= 1'b0;
                    end
                end
                S_PRGA: begin
                    if (w_step) begin
                        r_i        <= w_ip;
                        r_j        <= w_jp;
                        r_ks_valid <= 1'b1;
                        r_ks_data  <= w_s_t;
                    end
                end
                default: r_state <= S_LOAD;
            endcase
        end
    end

    assign o_key_ready = r_key_ready;
    assign o_busy      = r_busy;
    assign o_ks_valid  = r_ks_valid;
    assign o_ks_data   = r_ks_data;
endmodule

// File: tb/tb_rc4_stream.sv
// tb_rc4_stream: scoreboard bench for rc4_stream (plain and drop-256 instances)
module tb_rc4_stream;
    typedef logic [7:0] bq_t [$];

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic i_restart = 1'b0;
    logic i_key_valid = 1'b0;
    logic i_key_last = 1'b0;
    logic [7:0] i_key_data = '0;
    logic i_ks_ready = 1'b1;
    logic o_key_ready, o_ks_valid, o_busy;
    logic [7:0] o_ks_data;
    logic d2_key_ready, d2_ks_valid, d2_busy;
    logic [7:0] d2_ks_data;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int t_xfer = 0;
    bit stall_mode = 0;
    bit ready_fix = 1;
    bit lat_arm = 0;
    bit d2_arm = 0;
    logic [7:0] d2_exp;
    bit prev_stall = 0;
    logic [7:0] prev_data;
    logic [7:0] exp_q [$];

    bq_t key7 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
    bq_t key5 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    bq_t ref7 = '{8'h29, 8'h3f, 8'h02, 8'hd4, 8'h7f, 8'h37, 8'hc9, 8'hb6, 8'h33, 8'hf2, 8'haf, 8'h52};
    bq_t ref5 = '{8'hb2, 8'h39, 8'h63, 8'h05, 8'hf0, 8'h3d, 8'hc0, 8'h27, 8'hcc, 8'hc3, 8'h52, 8'h4a};

    rc4_stream #(.W(8), .MAX_KEY_LEN(32), .DROP_N(0)) dut (
        .clk(clk), .rst(rst), .i_restart(i_restart),
        .i_key_valid(i_key_valid), .o_key_ready(o_key_ready),
        .i_key_data(i_key_data), .i_key_last(i_key_last),
        .o_ks_valid(o_ks_valid), .i_ks_ready(i_ks_ready),
        .o_ks_data(o_ks_data), .o_busy(o_busy)
    );

    rc4_stream #(.W(8), .MAX_KEY_LEN(32), .DROP_N(256)) dut_drop (
        .clk(clk), .rst(rst), .i_restart(i_restart),
        .i_key_valid(i_key_valid), .o_key_ready(d2_key_ready),
        .i_key_data(i_key_data), .i_key_last(i_key_last),
        .o_ks_valid(d2_ks_valid), .i_ks_ready(1'b1),
        .o_ks_data(d2_ks_data), .o_busy(d2_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        i_ks_ready = stall_mode ? 1'($urandom_range(0, 1)) : ready_fix;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Straightforward software RC4: word idx of the stream after the key schedule
    function automatic logic [7:0] rc4_word(input bq_t key, input int idx);
        int s [256];
        int j = 0;
        int i = 0;
        int tmp;
        for (int n = 0; n < 256; n++) s[n] = n;
        for (int n = 0; n < 256; n++) begin
            j = (j + s[n] + int'(key[n % key.size()])) % 256;
            tmp = s[n]; s[n] = s[j]; s[j] = tmp;
        end
        j = 0;
        for (int k = 0; k <= idx; k++) begin
            i = (i + 1) % 256;
            j = (j + s[i]) % 256;
            tmp = s[i]; s[i] = s[j]; s[j] = tmp;
            if (k == idx) return 8'(s[(s[i] + s[j]) % 256]);
        end
        return 8'h00;
    endfunction

    always @(negedge clk) begin
        chk("busy_excl", {31'd0, o_busy & (o_key_ready | o_ks_valid)}, 0);
        if (prev_stall) begin
            chk("stall_valid", {31'd0, o_ks_valid}, 1);
            chk("stall_data", {24'd0, o_ks_data}, {24'd0, prev_data});
        end
        prev_stall = o_ks_valid && !i_ks_ready && !i_restart && !rst;
        prev_data = o_ks_data;
        if (lat_arm && o_ks_valid) begin
            chk("latency", cyc - t_xfer + 1, 514);
            lat_arm = 0;
        end
        if (o_ks_valid && i_ks_ready && exp_q.size() > 0)
            chk("ks_data", {24'd0, o_ks_data}, {24'd0, exp_q.pop_front()});
        if (d2_arm && d2_ks_valid) begin
            chk("drop_first", {24'd0, d2_ks_data}, {24'd0, d2_exp});
            chk("drop_latency", cyc - t_xfer + 1, 770);
            d2_arm = 0;
        end
    end

    task automatic load_key(input bq_t key, input bit use_last, input bit done);
        foreach (key[k]) begin
            i_key_valid = 1'b1;
            i_key_data = key[k];
            i_key_last = use_last && (k == key.size() - 1);
            @(negedge clk);
            chk("key_ready", {31'd0, o_key_ready}, 1);
            t_xfer = cyc + 1;
            @(posedge clk); #1;
        end
        if (done) begin
            chk("key_ready_off", {31'd0, o_key_ready}, 0);
            chk("busy_on", {31'd0, o_busy}, 1);
        end
        i_key_valid = 1'b0;
        i_key_last = 1'b0;
    endtask

    task automatic do_restart();
        i_restart = 1'b1;
        @(posedge clk); #1;
        i_restart = 1'b0;
        exp_q.delete();
        chk("restart_ks_valid", {31'd0, o_ks_valid}, 0);
        chk("restart_key_ready", {31'd0, o_key_ready}, 1);
        chk("restart_busy", {31'd0, o_busy}, 0);
    endtask

    task automatic drain(input int budget);
        for (int c = 0; c < budget && exp_q.size() > 0; c++) @(posedge clk);
        #1;
        chk("drain_left", exp_q.size(), 0);
    endtask

    initial begin
        bq_t key32;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_key_ready", {31'd0, o_key_ready}, 1);
        chk("reset_ks_valid", {31'd0, o_ks_valid}, 0);
        chk("reset_ks_data", {24'd0, o_ks_data}, 0);
        chk("reset_busy", {31'd0, o_busy}, 0);

        // 56-bit key, free-flowing output, stray key words while busy
        foreach (ref7[k]) exp_q.push_back(ref7[k]);
        load_key(key7, 1, 1);
        lat_arm = 1;
        i_key_valid = 1'b1;
        i_key_data = 8'hff;
        drain(1500);
        i_key_valid = 1'b0;

        // 40-bit key, also arms the drop-256 instance against the model
        do_restart();
        foreach (ref5[k]) exp_q.push_back(ref5[k]);
        d2_exp = rc4_word(key5, 256);
        load_key(key5, 1, 1);
        lat_arm = 1;
        d2_arm = 1;
        drain(1500);
        for (int c = 0; c < 1000 && d2_arm; c++) @(posedge clk);
        #1;
        chk("drop_seen", {31'd0, d2_arm}, 0);

        // Random backpressure on the 56-bit stream
        do_restart();
        foreach (ref7[k]) exp_q.push_back(ref7[k]);
        load_key(key7, 1, 1);
        stall_mode = 1;
        drain(2500);
        stall_mode = 0;
        ready_fix = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Restart mid-PRGA with a word buffered, partial key abandoned by restart
        chk("buffered", {31'd0, o_ks_valid}, 1);
        do_restart();
        load_key('{8'haa, 8'hbb, 8'hcc}, 0, 0);
        do_restart();
        ready_fix = 1'b1;
        foreach (ref5[k]) exp_q.push_back(ref5[k]);
        load_key(key5, 1, 1);
        drain(1500);

        // Full-length key without key_last
        do_restart();
        key32 = {};
        for (int k = 0; k < 32; k++) key32.push_back(8'($urandom));
        for (int k = 0; k < 12; k++) exp_q.push_back(rc4_word(key32, k));
        load_key(key32, 0, 1);
        lat_arm = 1;
        drain(1500);

        // Reset during the key schedule
        do_restart();
        load_key(key5, 1, 1);
        repeat (300) @(posedge clk);
        #1;
        chk("mid_ksa_busy", {31'd0, o_busy}, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_key_ready", {31'd0, o_key_ready}, 1);
        chk("rst_ks_valid", {31'd0, o_ks_valid}, 0);
        chk("rst_ks_data", {24'd0, o_ks_data}, 0);
        chk("rst_busy", {31'd0, o_busy}, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule
